// File: rtl/seg_pkg.sv
// Shared helpers for seven-segment scanners: hex decode, blank pattern by
// polarity and a constant-foldable ceiling log2.
package seg_pkg;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 32'sd0;
    rem = value - 32'sd1;
    while (rem > 32'sd0) begin
      res = res + 32'sd1;
      rem = rem >>> 1;
    end
    return res;
  endfunction

  // Active-high pattern, bit 0 = segment a ... bit 6 = segment g, bit 7 = dp.
  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'h3F;
      4'h1:    pat = 8'h06;
      4'h2:    pat = 8'h5B;
      4'h3:    pat = 8'h4F;
      4'h4:    pat = 8'h66;
      4'h5:    pat = 8'h6D;
      4'h6:    pat = 8'h7D;
      4'h7:    pat = 8'h07;
      4'h8:    pat = 8'h7F;
      4'h9:    pat = 8'h6F;
      4'hA:    pat = 8'h77;
      4'hB:    pat = 8'h7C;
      4'hC:    pat = 8'h39;
      4'hD:    pat = 8'h5E;
      4'hE:    pat = 8'h79;
      4'hF:    pat = 8'h71;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

  function automatic logic [7:0] seg_off(input bit active_low);
    logic [7:0] pat;
    if (active_low) begin
      pat = 8'hFF;
    end else begin
      pat = 8'h00;
    end
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Free-running prescaler producing a one-cycle clock enable every DIV cycles.
module scan_tick
  import seg_pkg::*;
#(
  parameter int DIV = 80000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = (cnt_r == CNT_MAX);

  // Dwell counter; restarts on each tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner: per-frame snapshot of the hex word,
// digit select stepping on the prescaler tick, blanking and decode.
module seg_scan
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 6,
  parameter int DIV            = 80000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  localparam int SEL_W         = (clog2(N_DIGITS) < 1) ? 1 : clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  lz_suppress,
  output logic [SEL_W-1:0]      sel,
  output logic [3:0]            nibble,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);
  localparam logic [7:0]       SEG_OFF  = seg_off(SEG_ACTIVE_LOW);

  logic                  tick_s;
  logic                  wrap_s;
  logic [SEL_W-1:0]      sel_nxt_s;
  logic [SEL_W-1:0]      sel_r;
  logic [4*N_DIGITS-1:0] data_sh_r;
  logic [N_DIGITS-1:0]   dp_sh_r;
  logic [N_DIGITS-1:0]   en_sh_r;
  logic                  lz_sh_r;
  logic [4*N_DIGITS-1:0] data_src_s;
  logic [N_DIGITS-1:0]   dp_src_s;
  logic [N_DIGITS-1:0]   en_src_s;
  logic                  lz_src_s;
  logic                  zero_run_s;
  logic [3:0]            nib_s;
  logic                  dp_s;
  logic                  en_s;
  logic                  lead_zero_s;
  logic                  blank_s;
  logic [7:0]            pat_s;
  logic [7:0]            seg_s;
  logic [3:0]            nibble_r;
  logic [7:0]            seg_r;
  logic                  frame_start_r;

  scan_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // Next select and source selection: digit 0 decodes from the word being
  // snapshotted on this very edge, later digits from the held shadow.
  always_comb begin
    wrap_s = tick_s && (sel_r == SEL_LAST);
    if (sel_r == SEL_LAST) begin
      sel_nxt_s = '0;
    end else begin
      sel_nxt_s = sel_r + 1'b1;
    end
    if (wrap_s) begin
      data_src_s = data;
      dp_src_s   = dp_in;
      en_src_s   = digit_en;
      lz_src_s   = lz_suppress;
    end else begin
      data_src_s = data_sh_r;
      dp_src_s   = dp_sh_r;
      en_src_s   = en_sh_r;
      lz_src_s   = lz_sh_r;
    end
  end

  // Pick the upcoming digit and track whether all digits up to it are zero.
  always_comb begin
    zero_run_s  = 1'b1;
    nib_s       = 4'h0;
    dp_s        = 1'b0;
    en_s        = 1'b0;
    lead_zero_s = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      zero_run_s = zero_run_s && (data_src_s[4*(N_DIGITS-1-i) +: 4] == 4'h0);
      if (SEL_W'(i) == sel_nxt_s) begin
        nib_s       = data_src_s[4*(N_DIGITS-1-i) +: 4];
        dp_s        = dp_src_s[N_DIGITS-1-i];
        en_s        = en_src_s[N_DIGITS-1-i];
        lead_zero_s = zero_run_s && (i < N_DIGITS - 1);
      end else begin
        lead_zero_s = lead_zero_s;
      end
    end
  end

  // Blanking and polarity.
  always_comb begin
    blank_s = !en_s || (lz_src_s && lead_zero_s);
    pat_s   = hex2seg(nib_s) | {dp_s, 7'b000_0000};
    if (blank_s) begin
      seg_s = SEG_OFF;
    end else if (SEG_ACTIVE_LOW) begin
      seg_s = ~pat_s;
    end else begin
      seg_s = pat_s;
    end
  end

  // Select and display registers move together on the tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_r         <= SEL_LAST;
      nibble_r      <= 4'h0;
      seg_r         <= SEG_OFF;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= wrap_s;
      if (tick_s) begin
        sel_r    <= sel_nxt_s;
        nibble_r <= blank_s ? 4'h0 : nib_s;
        seg_r    <= seg_s;
      end
    end
  end

  // Frame snapshot, held stable until the next wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_sh_r <= '0;
      dp_sh_r   <= '0;
      en_sh_r   <= '0;
      lz_sh_r   <= 1'b0;
    end else if (wrap_s) begin
      data_sh_r <= data;
      dp_sh_r   <= dp_in;
      en_sh_r   <= digit_en;
      lz_sh_r   <= lz_suppress;
    end
  end

  assign sel         = sel_r;
  assign nibble      = nibble_r;
  assign seg         = seg_r;
  assign frame_start = frame_start_r;

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scanner for common-anode/cathode seven-segment banks: it latches a packed hex word once per frame and cycles a digit select across `N_DIGITS` positions at a programmable rate. It drives the matching hex-decoded segment pattern with decimal point, per-digit blanking and optional leading-zero suppression. It sits between the measurement/DA-value datapath and the board display pins and replaces the fixed 6-position scanner. Scan timing comes from a clock enable, not a derived clock.

## Interface
- `N_DIGITS`, 6: number of display positions, 1..8.
- `DIV`, 80000: `clk` cycles per digit dwell, ≥1.
- `SEG_ACTIVE_LOW`, 1: 1 inverts `seg` (segment on = 0).
- `SEL_W` (localparam): max(1, clog2(`N_DIGITS`)).
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `data`  in  4*N_DIGITS  hex digits; digit 0 (leftmost) = `data[4N-1:4N-4]`.
- `dp_in`  in  N_DIGITS  decimal point per digit; bit `N-1-i` belongs to digit i.
- `digit_en`  in  N_DIGITS  per-digit enable, same bit order; 0 blanks.
- `lz_suppress`  in  1  blank leading zero digits.
- `sel`  out  SEL_W  index of the digit currently driven.
- `nibble`  out  4  hex value of the current digit (0 when blanked).
- `seg`  out  8  `seg[6:0]` = g..a, `seg[7]` = dp, polarity per `SEG_ACTIVE_LOW`.
- `frame_start`  out  1  one-`clk` pulse when a new snapshot is taken.

## Operation
- Prescaler: `cnt` counts 0..DIV-1; `tick` = (`cnt` == DIV-1), combinational. On a tick edge `cnt` ← 0.
- Each tick: `sel` ← `sel`+1, wrapping N_DIGITS-1 → 0. `sel`, `nibble` and `seg` update on the same edge, with no skew between select and data.
- Snapshot: on a tick where `sel` wraps to 0, `data`, `dp_in`, `digit_en` and `lz_suppress` load into shadow registers.
  - Digit 0 of that frame is decoded from the new snapshot. The shadow is stable for the whole frame, so there is no tearing.
  - `frame_start` is 1 for exactly that cycle.
- Blanking, evaluated on the shadow values. Digit i is blank if either:
  - `digit_en` for i = 0, or
  - `lz_suppress`=1, i < N_DIGITS-1, and shadow nibbles 0..i are all 0.
- The last digit is never zero-suppressed.
- A blank digit drives `seg` = SEG_OFF (all segments and dp off) and `nibble` = 0.
- Decode, active-high pattern before polarity: 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F, A→0x77, b→0x7C, C→0x39, d→0x5E, E→0x79, F→0x71. dp sets bit 7.
- SEG_OFF = 0xFF if `SEG_ACTIVE_LOW`, else 0x00.
- Reset (`rst`=0 at a `clk` edge), values after that edge:
  - `cnt`=0, `sel`=N_DIGITS-1, `nibble`=0, `seg`=SEG_OFF, `frame_start`=0.
  - Shadow registers all 0.
- Reset mid-frame: immediate return to the reset state. The next frame starts cleanly from digit 0.

## Timing
- The first tick after reset release occurs at the DIV-th rising edge with `rst`=1. That edge takes the snapshot, sets `sel`=0 and pulses `frame_start`.
- Dwell = DIV cycles per digit; frame period = N_DIGITS*DIV cycles.
- Input-to-display latency: changes to `data`, `dp_in`, `digit_en` or `lz_suppress` become visible at the next frame start. Worst case is N_DIGITS*DIV cycles plus 1.
- DIV=1: tick every cycle, `sel` advances every edge, `frame_start` every N_DIGITS cycles.
- N_DIGITS=1: `sel` stays 0. Every tick is a frame start.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `seg_pkg`:
  - `hex2seg` function (active-high 8-bit pattern).
  - SEG_OFF helper selected by polarity.
  - `clog2` constant function.
- Sub-module `scan_tick`, parameters `DIV`, ports `clk`, `rst`, `tick`: the prescaler, reusable by other scanned peripherals.
- The top holds `sel`, the shadow registers, the blanking logic and the output registers.

## Test plan
- N=6, DIV=4, data=0x12345F, all enables 1, lz off:
  - `seg` per frame (active-low) = 0xF9,0xA4,0xB0,0x99,0x92,0x8E.
  - `sel` steps 0..5, each held 4 cycles. `frame_start` every 24 cycles.
- lz on, data=0x000120:
  - digits 0–2 = 0xFF; digit 3 = 0xF9; digit 4 = 0xA4; digit 5 = 0xC0.
  - With data=0 only digit 5 shows 0xC0.
- Change `data` mid-frame (during `sel`=2): remaining digits show the old value; the new value appears from the next `frame_start`.
- `dp_in`=6'b000100, `digit_en`=6'b111110 with data=0x888888:
  - digit 3 `seg`=0x00 (8 with dp);
  - digit 5 = 0xFF;
  - others 0x80.
- Assert `rst` low for 1 cycle at `sel`=4, mid-dwell:
  - `sel`=5, `seg`=0xFF, `cnt`=0 next cycle;
  - first tick after exactly DIV further cycles with `sel`=0.
- DIV=1, N=1, SEG_ACTIVE_LOW=0, data=0xA: `seg`=0x77 from the first edge after reset; `frame_start` high every cycle.
